// File: rtl/ped_crossing_ctrl.sv
// Pedestrian push-button front end: synchronise/debounce the button, latch a crossing
// request, then run WALK / flashing DON'T WALK / cooldown once traffic is held red.
`timescale 1ns/1ps
module ped_crossing_ctrl #(
  parameter int DEB_T   = 3,
  parameter int WALK_T  = 4,
  parameter int FLASH_T = 4,
  parameter int CD_T    = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_raw,
  input  logic             cross_ok,
  output logic             ped_req,
  output logic             walk,
  output logic             dont_walk,
  output logic             aborted,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int MAX_WF = (WALK_T > FLASH_T) ? WALK_T : FLASH_T;
  localparam int MAX_T  = (MAX_WF > CD_T) ? MAX_WF : CD_T;
  localparam int TMR_W  = $clog2(MAX_T + 1);
  localparam int DEB_W  = $clog2(DEB_T + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WALK, S_FLASH, S_COOL} state_t;

  logic             r_sync1, r_sync2;
  logic             r_deb_level;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_press;
  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_phase;
  logic             r_pending;

  state_t           w_state_next;
  logic [TMR_W-1:0] w_timer_next;
  logic             w_phase_next;
  logic             w_pending_next;
  logic             w_abort;
  logic             w_dw_next;

  // Debounce runs only on ticks; an accepted rising level yields a one-clk press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_deb_level <= 1'b0;
      r_deb_cnt   <= '0;
      r_press     <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (tick) begin
        if (r_sync2 != r_deb_level) begin
          if (r_deb_cnt == DEB_W'(DEB_T - 1)) begin
            r_deb_level <= r_sync2;
            r_deb_cnt   <= '0;
            r_press     <= r_sync2;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end else begin
          r_deb_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_phase_next   = r_phase;
    w_pending_next = r_pending;
    w_abort        = 1'b0;
    if (r_press && (r_state == S_WALK || r_state == S_FLASH || r_state == S_COOL))
      w_pending_next = 1'b1;
    case (r_state)
      S_IDLE: if (r_press) w_state_next = S_REQ;
      S_REQ: begin
        if (cross_ok) begin
          w_state_next = S_WALK;
          w_timer_next = TMR_W'(WALK_T);
        end
      end
      S_WALK, S_FLASH: begin
        // Losing cross_ok outranks any tick expiry on the same edge.
        if (!cross_ok) begin
          w_state_next = S_COOL;
          w_timer_next = TMR_W'(CD_T);
          w_abort      = 1'b1;
        end else if (tick) begin
          if (r_state == S_FLASH) w_phase_next = ~r_phase;
          if (r_timer == TMR_W'(1)) begin
            if (r_state == S_WALK) begin
              w_state_next = S_FLASH;
              w_timer_next = TMR_W'(FLASH_T);
              w_phase_next = 1'b1;
            end else begin
              w_state_next = S_COOL;
              w_timer_next = TMR_W'(CD_T);
            end
          end else begin
            w_timer_next = r_timer - TMR_W'(1);
          end
        end
      end
      S_COOL: begin
        if (tick) begin
          if (r_timer == TMR_W'(1)) begin
            w_state_next   = (r_pending || r_press) ? S_REQ : S_IDLE;
            w_pending_next = 1'b0;
          end else begin
            w_timer_next = r_timer - TMR_W'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_dw_next = 1'b1;
    if (w_state_next == S_WALK)       w_dw_next = 1'b0;
    else if (w_state_next == S_FLASH) w_dw_next = w_phase_next;
  end

  // Lamps and request are registered from the next state so they switch on the transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_phase   <= 1'b0;
      r_pending <= 1'b0;
      ped_req   <= 1'b0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      aborted   <= 1'b0;
      press_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_phase   <= w_phase_next;
      r_pending <= w_pending_next;
      ped_req   <= (w_state_next == S_REQ);
      walk      <= (w_state_next == S_WALK);
      dont_walk <= w_dw_next;
      aborted   <= w_abort;
      if (r_press && (press_cnt != {CNT_W{1'b1}}))
        press_cnt <= press_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: vector table for the main flow plus
// hand-written sequences for bounce, aborts, saturation and async reset.
`timescale 1ns/1ps
module tb_ped_crossing_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_raw = 1'b0;
  logic       cross_ok = 1'b0;
  logic       ped_req, walk, dont_walk, aborted;
  logic [7:0] press_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       tk, btn, cok;
    logic       req, wlk, dw, ab;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  ped_crossing_ctrl #(.DEB_T(3), .WALK_T(4), .FLASH_T(4), .CD_T(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_raw(btn_raw), .cross_ok(cross_ok),
    .ped_req(ped_req), .walk(walk), .dont_walk(dont_walk), .aborted(aborted),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic req, input logic wlk, input logic dw,
                         input logic ab, input logic [7:0] cnt);
    chk({nm, ".ped_req"},   32'(ped_req),   32'(req));
    chk({nm, ".walk"},      32'(walk),      32'(wlk));
    chk({nm, ".dont_walk"}, 32'(dont_walk), 32'(dw));
    chk({nm, ".aborted"},   32'(aborted),   32'(ab));
    chk({nm, ".press_cnt"}, 32'(press_cnt), 32'(cnt));
  endtask

  // One clock; outputs are sampled 1ns after the active edge.
  task automatic cyc(input logic tk);
    tick = tk;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Clean press and release, ticking every cycle.
  task automatic press_btn();
    btn_raw = 1'b1;
    cyc(0); cyc(0); cyc(1); cyc(1); cyc(1);
    btn_raw = 1'b0;
    cyc(0); cyc(0); cyc(1); cyc(1); cyc(1);
  endtask

  task automatic add(input int n, input logic tk, input logic btn, input logic cok,
                     input logic req, input logic wlk, input logic dw, input logic ab,
                     input logic [7:0] cnt);
    vec_t v;
    v.tk = tk; v.btn = btn; v.cok = cok;
    v.req = req; v.wlk = wlk; v.dw = dw; v.ab = ab; v.cnt = cnt;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    // Clean press with cross_ok low, release, then a full crossing.
    add(2, 0,1,0, 0,0,1,0,0);
    add(3, 1,1,0, 0,0,1,0,0);
    add(1, 0,1,0, 1,0,1,0,1);
    add(1, 1,1,0, 1,0,1,0,1);
    add(2, 0,0,0, 1,0,1,0,1);
    add(3, 1,0,0, 1,0,1,0,1);
    add(1, 0,0,1, 0,1,0,0,1);
    add(3, 1,0,1, 0,1,0,0,1);
    add(1, 0,0,1, 0,1,0,0,1);
    add(1, 1,0,1, 0,0,1,0,1);
    add(1, 1,0,1, 0,0,0,0,1);
    add(1, 1,0,1, 0,0,1,0,1);
    add(1, 1,0,1, 0,0,0,0,1);
    add(4, 1,0,1, 0,0,1,0,1);
    add(1, 0,0,1, 0,0,1,0,1);
    // Second request, then a press during WALK left pending through FLASH/COOLDOWN.
    add(2, 0,1,0, 0,0,1,0,1);
    add(3, 1,1,0, 0,0,1,0,1);
    add(1, 0,1,0, 1,0,1,0,2);
    add(2, 0,0,0, 1,0,1,0,2);
    add(3, 1,0,0, 1,0,1,0,2);
    add(2, 0,1,1, 0,1,0,0,2);
    add(3, 1,1,1, 0,1,0,0,2);
    add(1, 0,1,1, 0,1,0,0,3);
    add(1, 1,1,1, 0,0,1,0,3);
    add(1, 1,1,1, 0,0,0,0,3);
    add(1, 1,1,1, 0,0,1,0,3);
    add(1, 1,1,1, 0,0,0,0,3);
    add(3, 1,1,1, 0,0,1,0,3);
    add(1, 1,1,1, 1,0,1,0,3);
    // REQ with cross_ok already high lasts one clk; then an immediate abort.
    add(1, 0,0,1, 0,1,0,0,3);
    add(1, 0,0,0, 0,0,1,1,3);
    add(1, 0,0,0, 0,0,1,0,3);
    add(3, 1,0,0, 0,0,1,0,3);
    add(1, 0,0,1, 0,0,1,0,3);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_out("reset", 0, 0, 1, 0, 0);

    // Bounce: each high burst is seen by only two ticks.
    for (int r = 0; r < 5; r++) begin
      btn_raw = 1'b1;
      cyc(0); cyc(1); cyc(0); cyc(1);
      btn_raw = 1'b0;
      cyc(0); cyc(1); cyc(0); cyc(1);
      chk_out($sformatf("bounce%0d", r), 0, 0, 1, 0, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      btn_raw  = tbl[i].btn;
      cross_ok = tbl[i].cok;
      cyc(tbl[i].tk);
      $display("vec %0d tk=%0b btn=%0b cok=%0b -> req=%0b walk=%0b dw=%0b ab=%0b cnt=%0d",
               i, tbl[i].tk, tbl[i].btn, tbl[i].cok, ped_req, walk, dont_walk, aborted, press_cnt);
      chk_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].wlk, tbl[i].dw, tbl[i].ab, tbl[i].cnt);
    end

    // Abort on the 2nd WALK tick.
    cross_ok = 1'b0;
    press_btn();
    chk_out("ab1_req", 1, 0, 1, 0, 4);
    cross_ok = 1'b1;
    cyc(0);
    chk_out("ab1_walk", 0, 1, 0, 0, 4);
    cyc(1);
    cross_ok = 1'b0;
    cyc(1);
    chk_out("ab1_abort", 0, 0, 1, 1, 4);
    cyc(0);
    chk_out("ab1_cool", 0, 0, 1, 0, 4);
    cyc(1); cyc(1); cyc(1);
    cross_ok = 1'b1;
    cyc(0);
    chk_out("ab1_idle", 0, 0, 1, 0, 4);

    // Abort on the same edge as the FLASH expiry tick.
    cross_ok = 1'b0;
    press_btn();
    cross_ok = 1'b1;
    cyc(0);
    chk_out("ab2_walk", 0, 1, 0, 0, 5);
    repeat (4) cyc(1);
    chk_out("ab2_flash", 0, 0, 1, 0, 5);
    cyc(1); cyc(1); cyc(1);
    chk_out("ab2_flash3", 0, 0, 0, 0, 5);
    cross_ok = 1'b0;
    cyc(1);
    chk_out("ab2_abort", 0, 0, 1, 1, 5);
    cyc(0);
    chk_out("ab2_after", 0, 0, 1, 0, 5);
    cyc(1); cyc(1); cyc(1);

    // Saturation: presses in REQ still count.
    for (int p = 0; p < 255; p++) press_btn();
    $display("saturation run: press_cnt=%0d ped_req=%0b", press_cnt, ped_req);
    chk_out("sat", 1, 0, 1, 0, 8'hFF);

    // Asynchronous reset in the middle of WALK.
    cross_ok = 1'b1;
    cyc(0);
    chk_out("pre_rst_walk", 0, 1, 0, 0, 8'hFF);
    #3 rst = 1'b1;
    #1 chk_out("async_rst", 0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    cyc(0);
    chk_out("post_rst_idle", 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
Pedestrian push-button front end that sits directly upstream of traffic_light and shares the tick_prescaler tick.
- Synchronises and debounces a raw button, then latches a crossing request (ped_req) for the light controller.
- When the controller reports conflicting traffic red (cross_ok), it runs the WALK / flashing-DON'T-WALK / cooldown sequence.
- All timing is in ticks.

Parameters:
DEB_T, 3, consecutive ticks of stable sampled button level needed to accept a level change (>=1)
WALK_T, 4, ticks of steady WALK (>=1)
FLASH_T, 4, ticks of flashing DON'T WALK (>=1)
CD_T, 3, cooldown ticks before a new request may be raised (>=1)
CNT_W, 8, width of accepted-press counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
tick  input  1  one-clk-wide timebase pulse from tick_prescaler
btn_raw  input  1  raw asynchronous push-button, 1 = pressed
cross_ok  input  1  from light controller: conflicting traffic is red, crossing permitted
ped_req  output  1  crossing request to light controller
walk  output  1  steady WALK lamp
dont_walk  output  1  DON'T WALK lamp (flashes in FLASH)
aborted  output  1  one-clk pulse: crossing cut short because cross_ok dropped
press_cnt  output  CNT_W  accepted presses, saturating

Behaviour:
- Reset (async, any state): state=IDLE, sync flops=0, debounced level=0, deb counter=0, timer=0, pending=0, flash_phase=0.
- Output reset values: ped_req=0, walk=0, dont_walk=1, aborted=0, press_cnt=0. All outputs are registered.
- Synchroniser: 2-flop on btn_raw gives btn_s.
- Debounce, evaluated only on tick:
  - If btn_s != debounced level, increment deb counter; otherwise clear it.
  - When the counter reaches DEB_T, the debounced level takes btn_s and the counter clears.
  - A 0->1 debounced transition produces a one-clk internal press pulse.
- press pulse handling:
  - Every press increments press_cnt, saturating at all-ones.
  - In IDLE: next state REQ.
  - In REQ: no effect (request already pending).
  - In WALK, FLASH or COOLDOWN: sets pending=1.
- FSM:
  - IDLE: ped_req=0, walk=0, dont_walk=1. Leaves only on press.
  - REQ: ped_req=1, walk=0, dont_walk=1. On any clk edge with cross_ok=1 (not tick-gated): go to WALK, load timer=WALK_T. ped_req falls the same edge walk rises.
  - WALK: walk=1, dont_walk=0.
    - Each tick: timer decrements.
    - On a tick with timer==1: go to FLASH, timer=FLASH_T, flash_phase=1.
  - FLASH: walk=0, dont_walk=flash_phase.
    - Each tick: flash_phase toggles and timer decrements.
    - On a tick with timer==1: go to COOLDOWN, timer=CD_T.
  - COOLDOWN: walk=0, dont_walk=1, ped_req=0.
    - On a tick with timer==1: go to REQ if pending, else IDLE; pending clears.
- Abort: in WALK or FLASH, cross_ok=0 on a clk edge gives:
  - next state COOLDOWN, timer=CD_T, walk=0, dont_walk=1;
  - aborted=1 for exactly that one cycle.
  - Abort has priority over a simultaneous tick expiry.
- Simultaneous events:
  - press pulse and a COOLDOWN expiry on the same edge: pending is treated as 1, so next state is REQ.
  - cross_ok already 1 when REQ is entered: WALK begins on the next edge. REQ lasts exactly 1 clk.
- tick held high continuously is legal: each high cycle counts as one tick.

Test Plan:
- Reset mid-WALK: assert rst asynchronously between clk edges -> outputs immediately ped_req=0, walk=0, dont_walk=1, press_cnt=0; state IDLE.
- Bounce rejection: DEB_T=3, btn_raw high for 2 ticks then low, repeated 5 times -> press_cnt=0, ped_req stays 0.
- Clean press, cross_ok=0: btn_raw high for 4 ticks -> ped_req=1 after the 3rd tick (+1 clk), press_cnt=1, walk=0 while cross_ok=0.
- Full cycle: from REQ, raise cross_ok and hold -> next edge walk=1, ped_req=0. WALK lasts 4 ticks, then FLASH for 4 ticks with dont_walk pattern 1,0,1,0. Then 3 ticks of COOLDOWN with dont_walk=1, then IDLE.
- Pending press: press during WALK -> press_cnt=2, ped_req stays 0 through FLASH/COOLDOWN, and goes to 1 the edge after the COOLDOWN expiry tick.
- Abort: drop cross_ok at the 2nd WALK tick -> walk=0, dont_walk=1 next edge, aborted one-clk pulse, then COOLDOWN 3 ticks -> IDLE. Repeat with cross_ok dropping on the same edge as the FLASH expiry tick -> aborted=1 (abort wins).
